// File: rtl/sd_frame_loader.sv
// sd_frame_loader: reads NUM_SECTORS SD sectors starting at BASE_SECTOR
// and packs byte pairs into RGB444 frame-buffer writes.
module sd_frame_loader #(
  parameter logic [31:0] BASE_SECTOR = 32'h00010000,
  parameter int unsigned NUM_SECTORS = 8,
  parameter logic [23:0] TIMEOUT     = 24'd2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  sectors_done
);

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, ISSUE, RECEIVE, NEXT, DONE, ERROR
  } state_t;

  localparam logic [8:0]  LAST_SEC = 9'(NUM_SECTORS);
  localparam logic [23:0] T_LIM    = TIMEOUT - 24'd1;

  state_t      state, state_n;
  logic        av_q;
  logic        accept;
  logic        take;
  logic        last_byte;
  logic        restart;
  logic        idle_tmo;
  logic        phase;
  logic [9:0]  byte_cnt;
  logic [7:0]  hi;
  logic [23:0] tcnt;
  logic        unused_lo;

  assign unused_lo = ^sd_dout[3:0];

  assign accept    = sd_byte_available & ~av_q;
  assign take      = accept & (state == RECEIVE);
  assign last_byte = take & (byte_cnt == 10'd511);
  assign idle_tmo  = ~accept & (tcnt >= T_LIM);
  assign restart   = start & ((state == IDLE) |
                              (state == DONE) |
                              (state == ERROR));

  assign sd_rd      = (state == ISSUE);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign busy       = (state == WAIT_READY) | (state == ISSUE) |
                      (state == RECEIVE) | (state == NEXT);
  assign sd_address = BASE_SECTOR + {23'd0, sectors_done};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_n = WAIT_READY;
      end
      WAIT_READY: begin
        if (sd_ready)      state_n = ISSUE;
        else if (idle_tmo) state_n = ERROR;
      end
      ISSUE: begin
        if (!sd_ready) state_n = RECEIVE;
      end
      RECEIVE: begin
        if (last_byte)     state_n = NEXT;
        else if (idle_tmo) state_n = ERROR;
      end
      NEXT: begin
        if (sectors_done + 9'd1 == LAST_SEC) state_n = DONE;
        else                                 state_n = WAIT_READY;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      av_q         <= 1'b0;
      tcnt         <= '0;
      phase        <= 1'b0;
      byte_cnt     <= '0;
      hi           <= '0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      sectors_done <= '0;
    end else begin
      state <= state_n;
      av_q  <= sd_byte_available;
      fb_we <= take & phase;
      if (state_n != state || accept) begin
        tcnt <= '0;
      end else if (state == WAIT_READY || state == RECEIVE) begin
        tcnt <= tcnt + 24'd1;
      end
      if (restart) begin
        sectors_done <= '0;
        fb_addr      <= '0;
        phase        <= 1'b0;
        byte_cnt     <= '0;
      end else begin
        if (state == NEXT) sectors_done <= sectors_done + 9'd1;
        // saturate so a full 256-sector load never wraps the index
        if (fb_we && fb_addr != 16'hFFFF) fb_addr <= fb_addr + 16'd1;
        if (take) begin
          phase    <= ~phase;
          byte_cnt <= last_byte ? 10'd0 : byte_cnt + 10'd1;
          if (phase) fb_data <= {hi, sd_dout[7:4]};
          else       hi      <= sd_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_frame_loader.sv
// tb_sd_frame_loader: SD controller model feeding random byte streams,
// checked against a pixel-packing reference model.
`timescale 1ns/1ps
module tb_sd_frame_loader;

  localparam logic [31:0] BASE = 32'h100;
  localparam int NSEC = 2;
  localparam int TMO  = 100;
  localparam int NPIX = NSEC * 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sd_ready = 1'b1;
  logic        sd_byte_available = 1'b0;
  logic [7:0]  sd_dout = 8'h00;
  logic        sd_rd, fb_we, busy, done, error;
  logic [31:0] sd_address;
  logic [15:0] fb_addr;
  logic [11:0] fb_data;
  logic [8:0]  sectors_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int w_n = 0;
  int rd_edges = 0;
  logic rd_q = 1'b0;
  logic [15:0] w_addr [4096];
  logic [11:0] w_data [4096];
  logic [7:0]  bq [1024];
  int bn = 0;
  int w0 = 0;
  int last_cyc = 0;

  sd_frame_loader #(
    .BASE_SECTOR(BASE),
    .NUM_SECTORS(NSEC),
    .TIMEOUT(24'(TMO))
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sd_ready(sd_ready),
    .sd_byte_available(sd_byte_available),
    .sd_dout(sd_dout),
    .sd_rd(sd_rd),
    .sd_address(sd_address),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .busy(busy),
    .done(done),
    .error(error),
    .sectors_done(sectors_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fb_we && w_n < 4096) begin
      w_addr[w_n] = fb_addr;
      w_data[w_n] = fb_data;
      w_n++;
    end
    if (sd_rd && !rd_q) rd_edges++;
    rd_q = sd_rd;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_sd_rd"}, 32'(sd_rd), 0);
    chk({t, "_fb_we"}, 32'(fb_we), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_done"}, 32'(done), 0);
    chk({t, "_error"}, 32'(error), 0);
    chk({t, "_sectors"}, 32'(sectors_done), 0);
    chk({t, "_fb_addr"}, 32'(fb_addr), 0);
    chk({t, "_fb_data"}, 32'(fb_data), 0);
    chk({t, "_sd_address"}, sd_address, BASE);
  endtask

  task automatic begin_load();
    w0 = w_n;
    bn = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: normal, 1: stall after last byte, 2: reset during last byte
  task automatic serve_sector(input int nbytes, input logic [31:0] exp_addr,
                              input bit pat, input int start_at,
                              input int hold5_at, input int mode);
    bit seen = 1'b0;
    int h;
    logic [7:0] b;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sd_rd) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rd_seen", 32'(seen), 1);
    chk("sd_address", sd_address, exp_addr);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    chk("rd_held", 32'(sd_rd), 1);
    sd_ready = 1'b0;
    @(negedge clk);
    chk("rd_released", 32'(sd_rd), 0);
    for (int i = 0; i < nbytes; i++) begin
      b = pat ? ((bn % 2 == 1) ? 8'hCD : 8'hAB) : 8'($urandom);
      bq[bn] = b;
      bn++;
      sd_dout = b;
      sd_byte_available = 1'b1;
      last_cyc = cyc;
      if (mode == 2 && i == nbytes - 1) begin
        #2 reset = 1'b1;
        #1;
        return;
      end
      h = (i == hold5_at) ? 5 : int'($urandom_range(1, 3));
      repeat (h) @(negedge clk);
      sd_byte_available = 1'b0;
      sd_dout = 8'($urandom);
      repeat ($urandom_range(1, 2)) @(negedge clk);
      if (i == hold5_at) chk("level_once", w_n - w0, bn / 2);
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 32'(busy), 1);
        chk("ign_sectors", 32'(sectors_done), exp_addr - BASE);
        chk("ign_address", sd_address, exp_addr);
        chk("ign_fb_addr", 32'(fb_addr), bn / 2);
      end
    end
    if (mode == 0) sd_ready = 1'b1;
  endtask

  task automatic wait_done(input string t);
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({t, "_done"}, 32'(got), 1);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_error"}, 32'(error), 0);
    chk({t, "_sectors"}, 32'(sectors_done), NSEC);
  endtask

  task automatic check_load(input string t, input int nwr);
    int bad = 0;
    int first = 0;
    logic [11:0] e;
    chk({t, "_count"}, w_n - w0, nwr);
    for (int i = 0; i < nwr && w0 + i < w_n; i++) begin
      e = {bq[2*i], bq[2*i+1][7:4]};
      if (w_addr[w0+i] !== 16'(i) || w_data[w0+i] !== e) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    assert (bad == 0) else begin
      errors++;
      $error("FAIL %s_pixels bad=%0d at=%0d observed=%0h/%0h expected=%0h/%0h",
             t, bad, first, w_addr[w0+first], w_data[w0+first], first,
             {bq[2*first], bq[2*first+1][7:4]});
    end
  endtask

  initial begin
    int rd0;
    int bad;
    bit got;

    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sd_rd", 32'(sd_rd), 0);

    // pattern load, with an ignored start mid-sector
    begin_load();
    rd0 = rd_edges;
    pulse_start();
    chk("l1_start_busy", 32'(busy), 1);
    serve_sector(512, BASE, 1'b1, 100, -1, 0);
    serve_sector(512, BASE + 1, 1'b1, -1, -1, 0);
    wait_done("l1");
    check_load("l1", NPIX);
    chk("l1_rd_pulses", rd_edges - rd0, NSEC);
    chk("l1_fb_data", 32'(fb_data), 12'hABC);

    // random load from DONE, one byte held for five cycles
    begin_load();
    pulse_start();
    chk("l2_done_clr", 32'(done), 0);
    serve_sector(512, BASE, 1'b0, -1, 1, 0);
    serve_sector(512, BASE + 1, 1'b0, -1, 300, 0);
    wait_done("l2");
    check_load("l2", NPIX);

    // source stalls after 300 bytes
    begin_load();
    pulse_start();
    serve_sector(300, BASE, 1'b0, -1, -1, 1);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (error) begin
        got = 1'b1;
        break;
      end
    end
    chk("tmo_error", 32'(got), 1);
    chk("tmo_cycles", cyc - (last_cyc + 1), TMO);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_sd_rd", 32'(sd_rd), 0);
    chk("tmo_fb_addr", 32'(fb_addr), 150);
    chk("tmo_sectors", 32'(sectors_done), 0);
    check_load("tmo", 150);

    sd_ready = 1'b1;
    begin_load();
    pulse_start();
    chk("rst_err_clr", 32'(error), 0);
    serve_sector(512, BASE, 1'b0, -1, -1, 0);
    serve_sector(512, BASE + 1, 1'b0, -1, -1, 0);
    wait_done("l3");
    check_load("l3", NPIX);

    // reset while the 200th byte is in flight
    begin_load();
    pulse_start();
    serve_sector(200, BASE, 1'b0, -1, -1, 2);
    check_reset("abort");
    @(negedge clk);
    chk("abort_writes", w_n - w0, 99);
    sd_byte_available = 1'b0;
    sd_ready = 1'b1;
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || sd_rd) bad++;
    end
    chk("post_reset_idle", bad, 0);

    begin_load();
    pulse_start();
    serve_sector(512, BASE, 1'b0, -1, -1, 0);
    serve_sector(512, BASE + 1, 1'b0, -1, -1, 0);
    wait_done("l4");
    check_load("l4", NPIX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_frame_loader.md
SD_FRAME_LOADER -- requirements
Module: sd_frame_loader

Interface
REQ-001 SHALL have parameter BASE_SECTOR, default 32'h00010000, meaning SD address of the first image sector.
REQ-002 SHALL have parameter NUM_SECTORS, default 8, range 1..256, meaning sectors per frame load.
REQ-003 SHALL have parameter TIMEOUT, default 24'd2_500_000, meaning maximum idle cycles in WAIT_READY or RECEIVE.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops are clocked on posedge clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that begins a load.
REQ-007 SHALL have port sd_ready, input, 1, SD controller idle/ready.
REQ-008 SHALL have port sd_byte_available, input, 1, SD read byte valid (level).
REQ-009 SHALL have port sd_dout, input, 8, SD read byte.
REQ-010 SHALL have port sd_rd, output, 1, read request to the SD controller.
REQ-011 SHALL have port sd_address, output, 32, sector address to the SD controller.
REQ-012 SHALL have port fb_we, output, 1, frame-buffer write strobe.
REQ-013 SHALL have port fb_addr, output, 16, frame-buffer pixel index.
REQ-014 SHALL have port fb_data, output, 12, RGB444 pixel.
REQ-015 SHALL have ports busy, done and error, output, 1 each, giving load status.
REQ-016 SHALL have port sectors_done, output, 9, count of completed sectors.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT_READY, ISSUE, RECEIVE, NEXT, DONE and ERROR.
REQ-018 SHALL move IDLE, DONE or ERROR -> WAIT_READY on start and clear sector count, pixel index, phase, done and error; start in any other state SHALL be ignored.
REQ-019 SHALL move WAIT_READY -> ISSUE in the cycle after sd_ready is sampled high.
REQ-020 SHALL drive sd_rd=1 in ISSUE until sd_ready is sampled low, then go to RECEIVE; sd_rd SHALL be 0 in every other state.
REQ-021 SHALL drive sd_address = BASE_SECTOR + sector count, held stable from WAIT_READY through RECEIVE.
REQ-022 SHALL accept a byte only on a rising edge of sd_byte_available (registered previous value); a level held high SHALL count as one byte.
REQ-023 SHALL treat even accepted bytes (phase 0) as hi, latched internally, with no write.
REQ-024 SHALL on odd accepted bytes (phase 1) assert fb_we for exactly one cycle, with fb_data={hi, sd_dout[7:4]} and fb_addr equal to the current pixel index, then increment the pixel index.
REQ-025 SHALL move RECEIVE -> NEXT after the 512th accepted byte of the sector (byte counter 0..511, 10-bit); bytes accepted outside RECEIVE SHALL be discarded.
REQ-026 SHALL in NEXT increment sectors_done and go to DONE if it equals NUM_SECTORS, else to WAIT_READY.
REQ-027 SHALL in DONE set done=1 and busy=0 and hold outputs until the next start.
REQ-028 SHALL keep busy=1 in WAIT_READY, ISSUE, RECEIVE and NEXT.
REQ-029 SHALL clear the timeout counter on state entry and on every accepted byte; reaching TIMEOUT in WAIT_READY or RECEIVE SHALL go to ERROR.
REQ-030 SHALL in ERROR set error=1 and busy=0, drive sd_rd=0 and fb_we=0, and preserve sectors_done and fb_addr.
REQ-031 SHALL make the last pixel written per load have fb_addr = NUM_SECTORS*256-1; fb_addr SHALL not wrap within a load.
REQ-032 SHALL give a rising edge coinciding with the RECEIVE -> NEXT transition no effect beyond that byte.

Reset
REQ-033 SHALL on reset asserted, immediately and asynchronously, put the state in IDLE and drive sd_rd=0, fb_we=0, busy=0, done=0, error=0, sectors_done=0, fb_addr=0, fb_data=0 and sd_address=BASE_SECTOR.
REQ-034 SHALL on reset mid-load abort without completing the pending pixel write; the first cycle after release SHALL be IDLE with no request issued until start.

Verification
REQ-035 SHALL cover full load: NUM_SECTORS=2, model supplies bytes 8'hAB,8'hCD repeating -> 512 writes, fb_data=12'hABC, fb_addr 0..511, done=1, sectors_done=2.
REQ-036 SHALL cover addressing: BASE_SECTOR=32'h100 -> sd_address 32'h100 then 32'h101, with one sd_rd assertion per sector released when sd_ready falls.
REQ-037 SHALL cover a level held: sd_byte_available held high 5 cycles for one byte -> exactly one byte accepted.
REQ-038 SHALL cover timeout: TIMEOUT=100, model stops after 300 bytes -> error=1 at 100 idle cycles, busy=0, fb_addr=150, and a later start restarts from sector 0.
REQ-039 SHALL cover reset at byte 200 -> all outputs at reset values, and a subsequent start loads correctly from fb_addr 0.
REQ-040 SHALL cover start while busy in RECEIVE -> ignored, with the count and address undisturbed.
